// File: rtl/uart_tx_fifo_if.sv
// IO-bus and emitter-side signal bundle for the UART transmit FIFO.
// Handshake: a byte moves on a rising edge where tx_valid && tx_ready; tx_valid
// never depends on tx_ready, and tx_data stays stable while tx_valid is high and
// the byte has not been taken.
interface uart_tx_fifo_if;
  logic        io_wr;
  logic [31:0] io_addr;
  logic [31:0] io_wdata;
  logic [31:0] io_rdata;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        full;

  modport slave (
    input  io_wr, io_addr, io_wdata, tx_ready,
    output io_rdata, tx_data, tx_valid, full
  );

  modport master (
    output io_wr, io_addr, io_wdata, tx_ready,
    input  io_rdata, tx_data, tx_valid, full
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// Memory-mapped UART transmit FIFO: IO byte stores are queued first-word-fall-through
// and drained to the emitter; the status register reports level, full/empty and overflow.
module uart_tx_fifo #(
  parameter int DEPTH    = 16,
  parameter int DATA_BIT = 1,
  parameter int STAT_BIT = 2
) (
  input  logic           clk,
  input  logic           resetn,
  uart_tx_fifo_if.slave  bus
);
  localparam int            AW       = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW:0]   count;
  logic          ovf;

  logic push, pop, accept, overflow, ovf_clr, is_full, is_empty;
  logic [31:0] status;

  assign is_full  = (count == FULL_CNT);
  assign is_empty = (count == '0);
  assign push     = bus.io_wr & bus.io_addr[DATA_BIT+2];
  assign pop      = bus.tx_valid & bus.tx_ready;
  // A full FIFO still accepts a byte when the head leaves in the same cycle.
  assign accept   = push & (~is_full | pop);
  assign overflow = push & is_full & ~pop;
  assign ovf_clr  = bus.io_wr & bus.io_addr[STAT_BIT+2] & bus.io_wdata[11];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + 1'b1;
      if (pop)    rd_ptr <= rd_ptr + 1'b1;
      case ({accept, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (overflow)     ovf <= 1'b1;
      else if (ovf_clr) ovf <= 1'b0;
    end
  end

  // Storage is deliberately not reset; only the pointers define its contents.
  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr] <= bus.io_wdata[7:0];
  end

  always_comb begin
    status        = '0;
    status[7:0]   = 8'(count);
    status[9]     = is_full;
    status[10]    = is_empty;
    status[11]    = ovf;
  end

  assign bus.tx_data  = mem[rd_ptr];
  assign bus.tx_valid = ~is_empty;
  assign bus.full     = is_full;
  assign bus.io_rdata = bus.io_addr[STAT_BIT+2] ? status : 32'h0;

  logic unused_bits;
  assign unused_bits = ^{bus.io_addr, bus.io_wdata};
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: directed writes, a byte scoreboard checked
// by an emitter-side monitor, and direct status-register checks.
module tb_uart_tx_fifo;
  localparam logic [31:0] DATA_ADDR = 32'h0000_0008;
  localparam logic [31:0] STAT_ADDR = 32'h0000_0010;

  logic clk;
  logic resetn;
  int   total = 0;
  int   bad   = 0;
  logic [7:0] exp_q[$];

  uart_tx_fifo_if bus ();

  uart_tx_fifo #(.DEPTH(16), .DATA_BIT(1), .STAT_BIT(2)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Driver tasks: called at posedge+1, return at the following posedge+1
  task automatic wr(input logic [31:0] addr, input logic [31:0] data);
    bus.io_wr    = 1'b1;
    bus.io_addr  = addr;
    bus.io_wdata = data;
    @(posedge clk);
    #1;
    bus.io_wr    = 1'b0;
  endtask

  task automatic push_byte(input logic [7:0] b, input bit expect_accept);
    if (expect_accept) exp_q.push_back(b);
    wr(DATA_ADDR, {24'h0, b});
  endtask

  task automatic read_stat(output logic [31:0] v);
    bus.io_addr = STAT_ADDR;
    #1;
    v = bus.io_rdata;
  endtask

  task automatic wait_drain(input string name, input int want_cycles);
    int n;
    n = 0;
    while (bus.tx_valid && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (bus.tx_valid) begin
      total++;
      bad++;
      $display("FAIL %s: drain timeout after %0d cycles", name, n);
    end else if (want_cycles >= 0) begin
      check(name, n, want_cycles);
    end
  endtask

  // Monitor: a byte is taken at the next rising edge if valid && ready now
  always @(negedge clk) begin
    if (resetn && bus.tx_valid && bus.tx_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL pop_unexpected: got %h want none", bus.tx_data);
      end else begin
        check("pop_data", {24'h0, bus.tx_data}, {24'h0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    logic [31:0] s;
    bit done;
    resetn       = 1'b0;
    bus.io_wr    = 1'b0;
    bus.io_addr  = 32'h0;
    bus.io_wdata = 32'h0;
    bus.tx_ready = 1'b0;

    // Reset state
    #3;
    check("rst_valid", {31'h0, bus.tx_valid}, 32'h0);
    check("rst_full", {31'h0, bus.full}, 32'h0);
    check("rst_rdata_nonstat", bus.io_rdata, 32'h0);
    read_stat(s);
    check("rst_status", s, 32'h0000_0400);
    @(posedge clk);
    #1;
    resetn = 1'b1;
    @(posedge clk);
    #1;

    // 1: single byte passes straight through
    bus.tx_ready = 1'b1;
    push_byte(8'h41, 1'b1);
    check("t1_valid", {31'h0, bus.tx_valid}, 32'h1);
    check("t1_data", {24'h0, bus.tx_data}, 32'h41);
    @(posedge clk);
    #1;
    check("t1_valid_after_pop", {31'h0, bus.tx_valid}, 32'h0);
    read_stat(s);
    check("t1_status", s, 32'h0000_0400);

    // 2: fill with the emitter stalled
    bus.tx_ready = 1'b0;
    for (int i = 0; i < 16; i++) push_byte(8'(i), 1'b1);
    check("t2_full", {31'h0, bus.full}, 32'h1);
    read_stat(s);
    check("t2_status", s, 32'h0000_0210);

    // 3: overflow is dropped and sticky until cleared
    push_byte(8'h55, 1'b0);
    read_stat(s);
    check("t3_status_ovf", s, 32'h0000_0A10);
    check("t3_head", {24'h0, bus.tx_data}, 32'h00);
    wr(STAT_ADDR, 32'h0000_0800);
    read_stat(s);
    check("t3_status_clr", s, 32'h0000_0210);

    // 4: write into a full FIFO while the head leaves, then drain one per cycle
    bus.tx_ready = 1'b1;
    push_byte(8'h77, 1'b1);
    read_stat(s);
    check("t4_status", s, 32'h0000_0210);
    wait_drain("t4_drain_cycles", 16);
    read_stat(s);
    check("t4_status_empty", s, 32'h0000_0400);

    // 5: 20 bytes with random emitter stalls, wrapping the pointers
    done = 0;
    fork
      begin
        for (int i = 0; i < 20; i++) begin
          int guard;
          guard = 0;
          while (bus.full && guard < 100) begin
            @(posedge clk);
            #1;
            guard++;
          end
          push_byte(8'hA0 + 8'(i), 1'b1);
        end
        done = 1;
      end
      begin
        while (!done) begin
          bus.tx_ready = 1'($urandom_range(0, 1));
          @(posedge clk);
          #1;
        end
      end
    join
    bus.tx_ready = 1'b1;
    wait_drain("t5_drain", -1);

    // 6: asynchronous reset mid-drain drops the queued bytes
    bus.tx_ready = 1'b0;
    for (int i = 0; i < 5; i++) push_byte(8'hC0 + 8'(i), 1'b1);
    read_stat(s);
    check("t6_status_pre", s, 32'h0000_0005);
    bus.tx_ready = 1'b1;
    #1;
    resetn = 1'b0;
    exp_q.delete();
    #1;
    check("t6_valid_rst", {31'h0, bus.tx_valid}, 32'h0);
    check("t6_status_rst", bus.io_rdata, 32'h0000_0400);
    @(posedge clk);
    #1;
    resetn = 1'b1;
    push_byte(8'h3C, 1'b1);
    check("t6_post_data", {24'h0, bus.tx_data}, 32'h3C);
    wait_drain("t6_drain_cycles", 1);

    @(posedge clk);
    #1;
    check("scoreboard_empty", exp_q.size(), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
